// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 matrix keypad scanner. Drives one row low at a time,
//                samples the synchronised active-low columns at the end of
//                each row period, assembles a 16-bit frame snapshot every
//                four rows and debounces it frame-by-frame into press
//                (key_valid + key_code), held (key_down) and release
//                (key_release) indications.
//  Optional    : `define KEYPAD_REPEAT_EN adds auto-repeat of key_valid
//                while a key is held (REPEAT_DELAY / REPEAT_RATE frames).
//  Ports       : clk         - system clock
//                rst         - asynchronous reset, active-high
//                row_n[3:0]  - row drive, active-low, one row low at a time
//                col_n[3:0]  - column sense, active-low, asynchronous
//                key_valid   - one-cycle pulse: accepted press (or repeat)
//                key_code    - row*4 + col of the accepted key
//                key_down    - level: an accepted key is held
//                key_release - one-cycle pulse: accepted release
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter logic [15:0] SCAN_DIV        = 16'd50000,
    parameter int          DEBOUNCE_FRAMES = 5,
    parameter int          REPEAT_DELAY    = 50,
    parameter int          REPEAT_RATE     = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_release
);

    localparam logic [15:0] C_DIV_LAST = SCAN_DIV - 16'd1;
    localparam logic [3:0]  C_DEB      = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    logic [3:0]  r_col_meta;
    logic [3:0]  r_col_sync;
    logic [15:0] r_div;
    logic [1:0]  r_row;
    logic [11:0] r_frame;       // rows 0..2; row 3 is taken live at the frame tick
    state_t      r_state;
    logic [3:0]  r_deb_cnt;
    logic [3:0]  r_cand;

    logic        w_row_tick;
    logic        w_frame_tick;
    logic [15:0] w_snap;
    logic [4:0]  w_ones;
    logic [3:0]  w_code;
    logic        w_none;
    logic        w_single;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] C_REP_DELAY = 16'(REPEAT_DELAY);
    localparam logic [15:0] C_REP_RATE  = 16'(REPEAT_RATE);
    logic [15:0] r_rep_cnt;
    logic        r_rep_on;      // first repeat already issued, now pacing at RATE
`endif

    assign w_row_tick   = (r_div == C_DIV_LAST);
    assign w_frame_tick = w_row_tick && (r_row == 2'd3);
    assign w_snap       = {~r_col_sync, r_frame};

    // Population count and (for the single-key case) the index of the set bit
    always_comb begin
        w_ones = 5'd0;
        w_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_snap[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = 4'(i);
            end
        end
    end

    assign w_none   = (w_ones == 5'd0);
    assign w_single = (w_ones == 5'd1);

    // Two-flop synchroniser for the asynchronous column lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
        end else begin
            r_col_meta <= col_n;
            r_col_sync <= r_col_meta;
        end
    end

    // Row divider, row rotation and per-row capture. Sampling at the last
    // count of the row period absorbs synchroniser and line settling delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= 16'd0;
            r_row   <= 2'd0;
            row_n   <= 4'b1110;
            r_frame <= 12'd0;
        end else if (w_row_tick) begin
            r_div <= 16'd0;
            r_row <= r_row + 2'd1;
            row_n <= {row_n[2:0], row_n[3]};
            case (r_row)
                2'd0:    r_frame[3:0]  <= ~r_col_sync;
                2'd1:    r_frame[7:4]  <= ~r_col_sync;
                2'd2:    r_frame[11:8] <= ~r_col_sync;
                default: ;
            endcase
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // Debounce FSM, evaluated on frame ticks only; pulses last one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_deb_cnt   <= 4'd0;
            r_cand      <= 4'd0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            key_down    <= 1'b0;
            key_release <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= 16'd0;
            r_rep_on    <= 1'b0;
`endif
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (w_frame_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_single) begin
                            r_cand    <= w_code;
                            r_deb_cnt <= 4'd1;
                            if (C_DEB == 4'd1) begin
                                key_code  <= w_code;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                r_state   <= HELD;
                            end else begin
                                r_state <= PRESS_DEB;
                            end
                        end
                    end
                    PRESS_DEB: begin
                        if (w_single && (w_code == r_cand)) begin
                            r_deb_cnt <= r_deb_cnt + 4'd1;
                            if ((r_deb_cnt + 4'd1) == C_DEB) begin
                                key_code  <= r_cand;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                r_state   <= HELD;
                            end
                        end else if (w_single) begin
                            r_cand    <= w_code;
                            r_deb_cnt <= 4'd1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (w_none) begin
                            r_deb_cnt <= 4'd1;
                            if (C_DEB == 4'd1) begin
                                key_down    <= 1'b0;
                                key_release <= 1'b1;
                                r_state     <= IDLE;
`ifdef KEYPAD_REPEAT_EN
                                r_rep_cnt   <= 16'd0;
                                r_rep_on    <= 1'b0;
`endif
                            end else begin
                                r_state <= REL_DEB;
                            end
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (r_rep_on ? ((r_rep_cnt + 16'd1) == C_REP_RATE)
                                         : ((r_rep_cnt + 16'd1) == C_REP_DELAY)) begin
                                key_valid <= 1'b1;
                                r_rep_cnt <= 16'd0;
                                r_rep_on  <= 1'b1;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 16'd1;
                            end
`endif
                        end
                    end
                    REL_DEB: begin
                        if (w_none) begin
                            r_deb_cnt <= r_deb_cnt + 4'd1;
                            if ((r_deb_cnt + 4'd1) == C_DEB) begin
                                key_down    <= 1'b0;
                                key_release <= 1'b1;
                                r_state     <= IDLE;
`ifdef KEYPAD_REPEAT_EN
                                r_rep_cnt   <= 16'd0;
                                r_rep_on    <= 1'b0;
`endif
                            end
                        end else begin
                            // Repeat counter is left untouched: it resumes in HELD
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan
//  Description : Self-checking bench for keypad_scan (SCAN_DIV=4,
//                DEBOUNCE_FRAMES=3, REPEAT_DELAY=4, REPEAT_RATE=2). A keypad
//                model shorts rows to columns for the pressed-key mask; a
//                frame-level reference model predicts press, release and
//                repeat events from runs of identical frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    localparam logic [15:0] SCAN_DIV = 16'd4;
    localparam int          DEB      = 3;
    localparam int          RD       = 4;
    localparam int          RR       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic        key_release;
    logic [15:0] keys;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_down    (key_down),
        .key_release (key_release)
    );

    // Physical keypad: a pressed key connects its row line to its column line
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    // ---------------- frame-level reference model ----------------
    logic       m_down;
    logic [3:0] m_code;
    logic [3:0] m_run_code;
    int         m_single_run, m_none_run, m_held, m_prev_cnt;

    task automatic model_reset();
        m_down = 1'b0; m_code = 4'd0; m_run_code = 4'd0;
        m_single_run = 0; m_none_run = 0; m_held = 0; m_prev_cnt = 0;
    endtask

    task automatic model_frame(input logic [15:0] mask, output logic ev_v, output logic ev_r);
        int cnt;
        logic [3:0] code;
        cnt = 0; code = 4'd0;
        for (int i = 0; i < 16; i++) if (mask[i]) begin cnt++; code = 4'(i); end
        if (cnt == 1 && m_single_run > 0 && code == m_run_code) m_single_run++;
        else if (cnt == 1) begin m_single_run = 1; m_run_code = code; end
        else m_single_run = 0;
        m_none_run = (cnt == 0) ? m_none_run + 1 : 0;
        ev_v = 1'b0; ev_r = 1'b0;
        if (!m_down) begin
            if (m_single_run == DEB) begin
                m_down = 1'b1; m_code = m_run_code; ev_v = 1'b1; m_held = 0;
            end
        end else if (m_none_run == DEB) begin
            m_down = 1'b0; ev_r = 1'b1;
        end else if (cnt != 0 && m_prev_cnt != 0) begin
            // frames spent held with a key visible, counted since acceptance
            m_held++;
`ifdef KEYPAD_REPEAT_EN
            if (m_held >= RD && ((m_held - RD) % RR) == 0) ev_v = 1'b1;
`endif
        end
        m_prev_cnt = cnt;
    endtask

    // ---------------- one frame of stimulus with trace capture ----------------
    logic [47:0] obs_evt, exp_evt;   // {valid[16], release[16], down[16]}
    logic [63:0] obs_cr,  exp_cr;    // per cycle nibbles of code
    logic [63:0] obs_row, exp_row;

    task automatic drive_frame(input logic [15:0] mask);
        logic       pd, ev_v, ev_r;
        logic [3:0] pc;
        keys = mask;
        pd = m_down; pc = m_code;
        model_frame(mask, ev_v, ev_r);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            obs_evt[32+c-1]     = key_valid;
            obs_evt[16+c-1]     = key_release;
            obs_evt[c-1]        = key_down;
            obs_cr[4*(c-1)+:4]  = key_code;
            obs_row[4*(c-1)+:4] = row_n;
            exp_evt[32+c-1]     = (c == 16) ? ev_v : 1'b0;
            exp_evt[16+c-1]     = (c == 16) ? ev_r : 1'b0;
            exp_evt[c-1]        = (c == 16) ? m_down : pd;
            exp_cr[4*(c-1)+:4]  = (c == 16) ? m_code : pc;
            exp_row[4*(c-1)+:4] = ~(4'b0001 << ((c / 4) % 4));
        end
    endtask

    // Reset asserted; release so that the next rising edge is cycle 1 of a frame
    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        keys = 16'h0000;
        rst  = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({key_valid, key_code, key_down, key_release, row_n} !== {1'b0, 4'h0, 1'b0, 1'b0, 4'b1110}) begin
            n_bad++;
            $display("FAIL reset_values: got v=%b c=%h d=%b r=%b row=%b, want 0 0 0 0 1110",
                     key_valid, key_code, key_down, key_release, row_n);
        end
        apply_reset();
        for (int f = 0; f < 13; f++) begin
            drive_frame(16'h0000);
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL idle_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
            n_cmp++;
            if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL idle_code_row f%0d: got %h/%h want %h/%h", f, obs_cr, obs_row, exp_cr, exp_row); end
        end
    endtask

    task automatic test_press_release();
        logic [15:0] seq [9] = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int f = 0; f < 9; f++) begin
            drive_frame(seq[f]);
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL press9_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
            n_cmp++;
            if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL press9_code_row f%0d: got %h/%h want %h/%h", f, obs_cr, obs_row, exp_cr, exp_row); end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] seq [9] = '{16'h0020, 16'h0020, 16'h0000, 16'h0020, 16'h0020,
                                 16'h0020, 16'h0000, 16'h0000, 16'h0000};
        for (int f = 0; f < 9; f++) begin
            drive_frame(seq[f]);
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL bounce_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
            n_cmp++;
            if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL bounce_code_row f%0d: got %h/%h want %h/%h", f, obs_cr, obs_row, exp_cr, exp_row); end
        end
    endtask

    task automatic test_multi();
        for (int f = 0; f < 16; f++) begin
            drive_frame(f < 10 ? 16'h8001 : (f < 13 ? 16'h0001 : 16'h0000));
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL multi_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
            n_cmp++;
            if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL multi_code_row f%0d: got %h/%h want %h/%h", f, obs_cr, obs_row, exp_cr, exp_row); end
        end
    endtask

    task automatic test_reset_midop();
        for (int f = 0; f < 5; f++) begin
            drive_frame(f < 4 ? 16'h0008 : 16'h0000);   // last frame leaves key 3 releasing
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL midrst_pre_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
        end
        keys = 16'h0008;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({key_valid, key_code, key_down, key_release, row_n} !== {1'b0, 4'h0, 1'b0, 1'b0, 4'b1110}) begin
            n_bad++;
            $display("FAIL midrst_async: got v=%b c=%h d=%b r=%b row=%b, want 0 0 0 0 1110",
                     key_valid, key_code, key_down, key_release, row_n);
        end
        apply_reset();
        for (int f = 0; f < 7; f++) begin
            drive_frame(f < 4 ? 16'h0008 : 16'h0000);
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL midrst_post_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
            n_cmp++;
            if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL midrst_code_row f%0d: got %h/%h want %h/%h", f, obs_cr, obs_row, exp_cr, exp_row); end
        end
    endtask

    // Long hold, brief release glitch (repeat pause), hold again, release
    task automatic test_repeat_hold();
        for (int f = 0; f < 23; f++) begin
            drive_frame((f < 12 || (f >= 14 && f < 20)) ? 16'h0008 : 16'h0000);
            n_cmp++;
            if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL hold_evt f%0d: got %h want %h", f, obs_evt, exp_evt); end
            n_cmp++;
            if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL hold_code_row f%0d: got %h/%h want %h/%h", f, obs_cr, obs_row, exp_cr, exp_row); end
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int sel, a, b, len;
        for (int run = 0; run < 40; run++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, 15);
            b   = (a + 1 + $urandom_range(0, 14)) % 16;
            len = $urandom_range(1, 5);
            if (sel < 3)      mask = 16'h0000;
            else if (sel < 9) mask = 16'h0001 << a;
            else              mask = (16'h0001 << a) | (16'h0001 << b);
            for (int f = 0; f < len; f++) begin
                drive_frame(mask);
                n_cmp++;
                if (obs_evt !== exp_evt) begin n_bad++; $display("FAIL rand_evt run%0d mask=%h: got %h want %h", run, mask, obs_evt, exp_evt); end
                n_cmp++;
                if ({obs_cr, obs_row} !== {exp_cr, exp_row}) begin n_bad++; $display("FAIL rand_code_row run%0d: got %h/%h want %h/%h", run, obs_cr, obs_row, exp_cr, exp_row); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_bounce();
        test_multi();
        test_reset_midop();
        test_repeat_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
